reset_sequencer: RTL



---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 15 +
 rtl/reset_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM states, limits and counter sizing for reset_sequencer
package reset_seq_pkg;

    localparam int MAX_STAGES = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN,
        ASSERT
    } state_e;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer, async active-low reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q_o, meta_q} <= 2'b00;
        else        {q_o, meta_q} <= {meta_q, d_i};

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged release of reset domains after clock lock.
// Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int WDT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  sw_rst_req,
    input  logic                  wdt_kick,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_done,
    output logic                  sw_rst_ack,
    output logic                  wdt_fired
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, WDT_CYCLES);
    localparam int SW = $clog2(MAX_STAGES);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [SW-1:0]         stage_q;
    logic [NUM_STAGES-1:0] rst_q;
    logic                  done_q, ack_q, pend_q, locked_s, timeout;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (locked),
        .q_o   (locked_s)
    );

`ifdef RESET_SEQ_WDT_EN
    logic [CW-1:0] wdt_q;
    logic          fired_q;

    assign timeout = state_q == RUN && !wdt_kick && wdt_q == CW'(WDT_CYCLES - 1);

    // Counter is cleared on every path out of RUN so it re-enters RUN at zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wdt_q   <= '0;
            fired_q <= 1'b0;
        end else begin
            wdt_q <= (state_q != RUN || !locked_s || timeout || wdt_kick || sw_rst_req)
                     ? '0 : wdt_q + 1'b1;
            if (timeout && locked_s) fired_q <= 1'b1;
        end

    assign wdt_fired = fired_q;
`else
    logic unused_kick;

    assign unused_kick = wdt_kick;
    assign timeout     = 1'b0;
    assign wdt_fired   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            // Lock loss outranks everything else, including a pending ack
            if (!locked_s && state_q != WAIT_LOCK) begin
                state_q <= WAIT_LOCK;
                cnt_q   <= '0;
                stage_q <= '0;
                rst_q   <= '1;
                done_q  <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                case (state_q)
                    WAIT_LOCK: if (locked_s) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end
                    HOLD: if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        rst_q[0] <= 1'b0;
                        stage_q  <= SW'(1);
                        state_q  <= (NUM_STAGES == 1) ? RUN : RELEASE;
                        done_q   <= NUM_STAGES == 1;
                    end else cnt_q <= cnt_q + 1'b1;
                    RELEASE: if (cnt_q == CW'(STAGE_GAP - 1)) begin
                        cnt_q <= '0;
                        rst_q <= rst_q & ~(NUM_STAGES'(1) << stage_q);
                        if (stage_q == SW'(NUM_STAGES - 1)) begin
                            state_q <= RUN;
                            done_q  <= 1'b1;
                        end else stage_q <= stage_q + 1'b1;
                    end else cnt_q <= cnt_q + 1'b1;
                    RUN: begin
                        ack_q  <= pend_q;
                        pend_q <= sw_rst_req;
                        if (sw_rst_req || timeout) begin
                            state_q <= ASSERT;
                            rst_q   <= '1;
                            done_q  <= 1'b0;
                            stage_q <= '0;
                            cnt_q   <= '0;
                        end
                    end
                    ASSERT:  state_q <= HOLD;
                    default: state_q <= WAIT_LOCK;
                endcase
            end
        end

    assign rst_out    = rst_q;
    assign seq_done   = done_q;
    assign sw_rst_ack = ack_q;

endmodule
